debug_scan_engine: RTL and testbench
====================================

Name: debug_scan_engine

Overview:
- Parametrised multi-core debug scan engine that replaces per-core JTAG debug wrappers with one shared instance.
- Runs entirely in the system clock domain.
- Consumes already-synchronised virtual-JTAG state strobes and captures a per-core data word.
- Shifts the word serially, then on update issues a one-cycle take_action or take_no_action pulse to the addressed core and instruction.

Parameters:
NUM_CORES, 2, number of debug targets (1..16)
SR_W, 38, scan register / jdo width (>=8)
IR_W, 2, opcode bits per instruction
SEL_W, 4, core-select field width in ir_in (2**SEL_W >= NUM_CORES)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
tck_rise  in  1  one-cycle strobe; qualifies all vs_* and tdi
ir_in  in  IR_W+SEL_W  {core_sel, opcode}, sampled on UIR
vs_uir  in  1  update-IR state
vs_cdr  in  1  capture-DR state
vs_sdr  in  1  shift-DR state
vs_udr  in  1  update-DR state
tdi  in  1  serial data in
tdo  out  1  serial data out, equals sr[0]
capture_data  in  NUM_CORES*SR_W  per-core capture words; core k is at [k*SR_W +: SR_W]
jdo  out  SR_W  last completed scan word
take_action  out  NUM_CORES*2**IR_W  one-hot pulse; index = core*2**IR_W + opcode
take_no_action  out  NUM_CORES*2**IR_W  same indexing
err_clr  in  1  clears sticky error flags
sel_err  out  1  sticky: UIR selected core >= NUM_CORES
scan_err  out  1  sticky: bad scan length or update without capture
busy  out  1  high when state is not IDLE

Behaviour:
- Reset (reset_n=0 at a clk edge) forces the following to 0: sr, jdo, tdo, take_action, take_no_action, sel_err, scan_err, busy, opcode_q, sel_q, shift_cnt. State goes to IDLE. Reset mid-scan aborts the scan and produces no pulse.
- Events act only in a cycle with tck_rise=1.
- If more than one vs_* is high with tck_rise, priority is uir > udr > cdr > sdr. Only the highest-priority event acts.
- States:
  - IDLE: waiting for capture.
  - CAPT: word captured.
  - SHIFT: shifting in progress.
  - ISSUE: one cycle, drives the pulse.
- UIR (any state): opcode_q <= opcode and sel_q <= core_sel.
  - If core_sel >= NUM_CORES: sel_err <= 1.
  - State goes to IDLE, abandoning any partial scan with no error.
- CDR (any state except ISSUE):
  - sr <= capture_data slice at sel_q, or all zeros if sel_q is invalid.
  - shift_cnt <= 0; state goes to CAPT.
- SDR in CAPT or SHIFT:
  - sr <= {tdi, sr[SR_W-1:1]}.
  - shift_cnt increments and saturates at SR_W+1; state goes to SHIFT.
- SDR in IDLE: ignored.
- UDR in CAPT or SHIFT:
  - If shift_cnt == SR_W and sel_q is valid: jdo <= sr and state goes to ISSUE.
  - Otherwise: scan_err <= 1 (if the count is bad), jdo is unchanged, no pulse, state goes to IDLE.
  - A CAPT→UDR with zero shifts counts as a bad length.
- UDR in IDLE: scan_err <= 1.
- ISSUE (the cycle after a good UDR):
  - If jdo[SR_W-1]=1: take_action[idx] = 1.
  - Otherwise: take_no_action[idx] = 1.
  - Exactly one bit across both vectors is high, for exactly 1 clk. State returns to IDLE.
  - Latency from the UDR strobe cycle to the pulse is 1 clk.
  - A tck event arriving during ISSUE is ignored, except UIR, which is applied after the pulse.
- tdo is registered and equals sr[0] at all times.
- The sticky flags clear on err_clr. If a set and err_clr coincide, the set wins.
- The capture_data slice is sampled only in the CDR cycle. Changes afterwards do not affect the scan.

Test Plan:
- UIR ir_in={4'd1,2'd2}; CDR with core1 capture=38'h15_5555_5555; 38 SDR with tdi=1 → tdo sequence begins 1,0,1,0; on UDR, jdo=38'h3F_FFFF_FFFF, take_action[6]=1 for 1 clk, all other bits 0.
- Same scan shifting all zeros → take_no_action[6] pulse; take_action stays 0; jdo=0.
- 37 shifts then UDR → no pulse, scan_err=1, jdo holds its previous value; err_clr → scan_err=0.
- UIR core_sel=5 (NUM_CORES=2) → sel_err=1; full scan yields no pulse and sr captures 0.
- Reset asserted after 20 shifts → all outputs 0 the next clk; a subsequent UDR sets scan_err and produces no pulse.
- vs_uir and vs_udr both high with tck_rise → only the UIR acts: state IDLE, no pulse, scan_err unchanged.

Source files
------------

// File: rtl/debug_scan_engine.sv
// rtl/debug_scan_engine.sv - shared multi-core debug scan engine
// Captures a per-core word, shifts it serially and pulses the addressed core's action line.
module debug_scan_engine #(
  parameter int NUM_CORES = 2,
  parameter int SR_W      = 38,
  parameter int IR_W      = 2,
  parameter int SEL_W     = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         tck_rise,
  input  logic [IR_W+SEL_W-1:0]        ir_in,
  input  logic                         vs_uir,
  input  logic                         vs_cdr,
  input  logic                         vs_sdr,
  input  logic                         vs_udr,
  input  logic                         tdi,
  output logic                         tdo,
  input  logic [NUM_CORES*SR_W-1:0]    capture_data,
  output logic [SR_W-1:0]              jdo,
  output logic [NUM_CORES*(2**IR_W)-1:0] take_action,
  output logic [NUM_CORES*(2**IR_W)-1:0] take_no_action,
  input  logic                         err_clr,
  output logic                         sel_err,
  output logic                         scan_err,
  output logic                         busy
);

  localparam int NA = NUM_CORES * (2**IR_W);
  localparam int CW = $clog2(SR_W + 2);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CAPT  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_ISSUE = 2'd3;

  logic [1:0]      state;
  logic [SR_W-1:0] sr;
  logic [IR_W-1:0] opcode_q;
  logic [SEL_W-1:0] sel_q;
  logic [CW-1:0]   shift_cnt;
  logic [NA-1:0]   ta_q;
  logic [NA-1:0]   tna_q;

  logic            ev_uir, ev_udr, ev_cdr, ev_sdr;
  logic            sel_valid, new_sel_bad, shift_full;
  logic [SR_W-1:0] cap_word;
  logic [NA-1:0]   one_hot;

  // Only the highest-priority strobe acts: uir > udr > cdr > sdr.
  assign ev_uir = tck_rise & vs_uir;
  assign ev_udr = tck_rise & vs_udr & ~vs_uir;
  assign ev_cdr = tck_rise & vs_cdr & ~vs_uir & ~vs_udr;
  assign ev_sdr = tck_rise & vs_sdr & ~vs_uir & ~vs_udr & ~vs_cdr;

  assign sel_valid   = int'(sel_q) < NUM_CORES;
  assign new_sel_bad = int'(ir_in[IR_W+SEL_W-1:IR_W]) >= NUM_CORES;
  assign shift_full  = shift_cnt == CW'(SR_W);
  assign one_hot     = NA'(1) << {sel_q, opcode_q};

  always_comb begin
    cap_word = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (int'(sel_q) == k) cap_word = capture_data[k*SR_W +: SR_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      sr        <= '0;
      jdo       <= '0;
      opcode_q  <= '0;
      sel_q     <= '0;
      shift_cnt <= '0;
      ta_q      <= '0;
      tna_q     <= '0;
      sel_err   <= 1'b0;
      scan_err  <= 1'b0;
    end else begin
      ta_q  <= '0;
      tna_q <= '0;
      if (err_clr) begin
        sel_err  <= 1'b0;
        scan_err <= 1'b0;
      end
      // The pulse is already registered, so a UIR during ISSUE only affects later scans.
      if (ev_uir) begin
        opcode_q <= ir_in[IR_W-1:0];
        sel_q    <= ir_in[IR_W+SEL_W-1:IR_W];
        if (new_sel_bad) sel_err <= 1'b1;
        state <= S_IDLE;
      end else if (state == S_ISSUE) begin
        state <= S_IDLE;
      end else if (ev_udr) begin
        if (state == S_IDLE) begin
          scan_err <= 1'b1;
        end else if (shift_full && sel_valid) begin
          jdo   <= sr;
          state <= S_ISSUE;
          if (sr[SR_W-1]) ta_q  <= one_hot;
          else            tna_q <= one_hot;
        end else begin
          if (!shift_full) scan_err <= 1'b1;
          state <= S_IDLE;
        end
      end else if (ev_cdr) begin
        sr        <= cap_word;
        shift_cnt <= '0;
        state     <= S_CAPT;
      end else if (ev_sdr && state != S_IDLE) begin
        sr <= {tdi, sr[SR_W-1:1]};
        if (shift_cnt != CW'(SR_W + 1)) shift_cnt <= shift_cnt + CW'(1);
        state <= S_SHIFT;
      end
    end
  end

  assign tdo            = sr[0];
  assign take_action    = ta_q;
  assign take_no_action = tna_q;
  assign busy           = state != S_IDLE;

endmodule

// File: tb/tb_debug_scan_engine.sv
// tb/tb_debug_scan_engine.sv - scoreboard bench for debug_scan_engine
module tb_debug_scan_engine;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        tck_rise = 1'b0;
  logic [5:0]  ir_in = '0;
  logic        vs_uir = 1'b0, vs_cdr = 1'b0, vs_sdr = 1'b0, vs_udr = 1'b0;
  logic        tdi = 1'b0;
  logic        tdo;
  logic [75:0] capture_data = '0;
  logic [37:0] jdo;
  logic [7:0]  take_action, take_no_action;
  logic        err_clr = 1'b0;
  logic        sel_err, scan_err, busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  ta;
    logic [7:0]  tna;
    logic [37:0] jdo;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  debug_scan_engine #(.NUM_CORES(2), .SR_W(38), .IR_W(2), .SEL_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .tck_rise(tck_rise), .ir_in(ir_in),
    .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr),
    .tdi(tdi), .tdo(tdo), .capture_data(capture_data), .jdo(jdo),
    .take_action(take_action), .take_no_action(take_no_action),
    .err_clr(err_clr), .sel_err(sel_err), .scan_err(scan_err), .busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every pulse cycle pops one expectation; an extra or stretched pulse finds an empty queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && ((|take_action) || (|take_no_action))) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: got ta=%0h tna=%0h expected none", take_action, take_no_action);
        end else begin
          e = sb.pop_front();
          if (take_action !== e.ta || take_no_action !== e.tna || jdo !== e.jdo) begin
            errors++;
            $display("FAIL pulse: got ta=%0h tna=%0h jdo=%0h expected ta=%0h tna=%0h jdo=%0h",
                     take_action, take_no_action, jdo, e.ta, e.tna, e.jdo);
          end
        end
      end
    end
  end

  task automatic ev(input logic u, input logic c, input logic s, input logic d, input logic t);
    @(posedge clk); #1;
    tck_rise = 1'b1; vs_uir = u; vs_cdr = c; vs_sdr = s; vs_udr = d; tdi = t;
    @(posedge clk); #1;
    tck_rise = 1'b0; vs_uir = 1'b0; vs_cdr = 1'b0; vs_sdr = 1'b0; vs_udr = 1'b0; tdi = 1'b0;
  endtask

  task automatic uir(input logic [3:0] sel, input logic [1:0] op);
    ir_in = {sel, op};
    ev(1, 0, 0, 0, 0);
  endtask

  task automatic shifts(input int n, input logic t);
    for (int i = 0; i < n; i++) ev(0, 0, 1, 0, t);
  endtask

  task automatic clear_err();
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
  endtask

  task automatic drained(input string name);
    repeat (3) @(posedge clk);
    #1 chk(name, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    exp_t e;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tdo", 64'(tdo), 0);
    chk("rst_jdo", 64'(jdo), 0);
    chk("rst_ta", 64'(take_action), 0);
    chk("rst_tna", 64'(take_no_action), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_sel_err", 64'(sel_err), 0);
    chk("rst_scan_err", 64'(scan_err), 0);
    reset_n = 1'b1;

    // Good scan, core 1 opcode 2, all-ones shift -> take_action[6]
    capture_data = {38'h15_5555_5555, 38'h0};
    uir(4'd1, 2'd2);
    ev(0, 1, 0, 0, 0);
    capture_data = {38'h3F_FFFF_FFFF, 38'h0};
    chk("capt_busy", 64'(busy), 1);
    chk("tdo0", 64'(tdo), 1);
    shifts(1, 1); chk("tdo1", 64'(tdo), 0);
    shifts(1, 1); chk("tdo2", 64'(tdo), 1);
    shifts(1, 1); chk("tdo3", 64'(tdo), 0);
    shifts(35, 1);
    e.ta = 8'h40; e.tna = 8'h00; e.jdo = 38'h3F_FFFF_FFFF; sb.push_back(e);
    ev(0, 0, 0, 1, 0);
    drained("drain_action");
    chk("jdo_ones", 64'(jdo), 64'h3F_FFFF_FFFF);
    chk("idle_after_issue", 64'(busy), 0);

    // Same scan, all-zero shift -> take_no_action[6]
    capture_data = {38'h15_5555_5555, 38'h0};
    ev(0, 1, 0, 0, 0);
    shifts(38, 0);
    e.ta = 8'h00; e.tna = 8'h40; e.jdo = 38'h0; sb.push_back(e);
    ev(0, 0, 0, 1, 0);
    drained("drain_no_action");
    chk("jdo_zero", 64'(jdo), 0);

    // Short scan: 37 shifts
    ev(0, 1, 0, 0, 0);
    shifts(37, 1);
    ev(0, 0, 0, 1, 0);
    drained("drain_short");
    chk("short_scan_err", 64'(scan_err), 1);
    chk("short_jdo_hold", 64'(jdo), 0);
    chk("short_busy", 64'(busy), 0);
    clear_err();
    chk("err_clr_scan", 64'(scan_err), 0);

    // Capture immediately followed by update
    ev(0, 1, 0, 0, 0);
    ev(0, 0, 0, 1, 0);
    chk("zero_shift_err", 64'(scan_err), 1);
    clear_err();

    // Too many shifts also counts as a bad length
    ev(0, 1, 0, 0, 0);
    shifts(40, 1);
    ev(0, 0, 0, 1, 0);
    drained("drain_long");
    chk("long_scan_err", 64'(scan_err), 1);
    clear_err();

    // Invalid core select
    uir(4'd5, 2'd1);
    chk("sel_err_set", 64'(sel_err), 1);
    capture_data = {38'h15_5555_5555, 38'h2A_AAAA_AAAB};
    ev(0, 1, 0, 0, 0);
    chk("bad_sel_capture", 64'(tdo), 0);
    shifts(38, 1);
    ev(0, 0, 0, 1, 0);
    drained("drain_bad_sel");
    chk("bad_sel_scan_err", 64'(scan_err), 0);
    chk("bad_sel_jdo", 64'(jdo), 0);
    clear_err();
    chk("err_clr_sel", 64'(sel_err), 0);

    // Set coinciding with err_clr: set wins
    ir_in = {4'd7, 2'd0};
    @(posedge clk); #1 err_clr = 1'b1; tck_rise = 1'b1; vs_uir = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0; tck_rise = 1'b0; vs_uir = 1'b0;
    chk("set_beats_clr", 64'(sel_err), 1);
    clear_err();

    // UIR and UDR together after a full scan: only UIR acts
    uir(4'd1, 2'd2);
    ev(0, 1, 0, 0, 0);
    shifts(38, 0);
    ir_in = {4'd0, 2'd3};
    ev(1, 0, 0, 1, 0);
    drained("drain_uir_udr");
    chk("uir_udr_busy", 64'(busy), 0);
    chk("uir_udr_scan_err", 64'(scan_err), 0);
    chk("uir_udr_sel_err", 64'(sel_err), 0);

    // The new select (core 0, opcode 3) is now in effect
    capture_data = {38'h0, 38'h00_0000_0001};
    ev(0, 1, 0, 0, 0);
    chk("core0_tdo", 64'(tdo), 1);
    shifts(38, 1);
    e.ta = 8'h08; e.tna = 8'h00; e.jdo = 38'h3F_FFFF_FFFF; sb.push_back(e);
    ev(0, 0, 0, 1, 0);
    drained("drain_core0");

    // Reset mid-scan
    capture_data = {38'h0, 38'h15_5555_5555};
    ev(0, 1, 0, 0, 0);
    shifts(20, 1);
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    chk("mid_rst_tdo", 64'(tdo), 0);
    chk("mid_rst_jdo", 64'(jdo), 0);
    chk("mid_rst_busy", 64'(busy), 0);
    chk("mid_rst_ta", 64'(take_action), 0);
    ev(0, 0, 0, 1, 0);
    drained("drain_after_rst");
    chk("udr_after_rst_err", 64'(scan_err), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
